// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if
//   Bundles the datapath-facing signals of the 7-segment scan controller.
//   master : datapath side (drives i_data / i_load / i_lz_en, observes outputs)
//   slave  : scanner side  (samples inputs, drives o_nibble / o_anode / o_frame)
//   i_data   4*DIGITS  packed hex value, nibble k shown on digit k
//   i_load   1         capture strobe for i_data
//   i_lz_en  1         leading-zero suppression enable
//   o_nibble 4         nibble of the selected digit (to the hex decoder)
//   o_anode  DIGITS    active-low digit enables
//   o_frame  1         pulse on the last cycle of the top digit's slot
interface seven_seg_scanner_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] i_data;
    logic                i_load;
    logic                i_lz_en;
    logic [3:0]          o_nibble;
    logic [DIGITS-1:0]   o_anode;
    logic                o_frame;

    modport master (
        output i_data, i_load, i_lz_en,
        input  o_nibble, o_anode, o_frame
    );

    modport slave (
        input  i_data, i_load, i_lz_en,
        output o_nibble, o_anode, o_frame
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed scan controller for a common-anode 7-segment display.
//   A shadow register captures the packed hex word on i_load; a slot counter
//   and digit index walk the digits, each held for SLOT_CYCLES clocks with
//   the first GUARD_CYCLES of every slot blanked to avoid ghosting.
//   i_clk  system clock
//   i_rst  synchronous active-high reset
//   bus    seven_seg_scanner_if.slave (data/load/lz_en in; nibble/anode/frame out)
module seven_seg_scanner #(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    seven_seg_scanner_if.slave   bus
);
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;

    logic                slot_end;
    logic                guard_done;
    logic [DIGITS-1:0]   supp;
    logic                upper_zero;
    logic [DIGITS-1:0]   anode_nxt;

    assign slot_end = (cnt == CNT_LAST);

    // The guard comparison is only built when there is a guard, so a zero
    // guard does not leave a constant-true compare behind.
    generate
        if (GUARD_CYCLES > 0) begin : g_guard
            assign guard_done = (cnt >= CW'(GUARD_CYCLES));
        end else begin : g_noguard
            assign guard_done = 1'b1;
        end
    endgenerate

    // Digit k is dark when every nibble from the top down to k is zero.
    // Scanning from the top keeps a running "all zero so far" flag; digit 0
    // is never part of the mask so a zero value still shows one "0".
    always_comb begin
        supp       = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (shadow[4*k +: 4] == 4'd0);
            supp[k]    = bus.i_lz_en && upper_zero;
        end
    end

    always_comb begin
        anode_nxt = '1;
        if (guard_done && !supp[idx])
            anode_nxt[idx] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow       <= '0;
            cnt          <= '0;
            idx          <= '0;
            bus.o_nibble <= 4'd0;
            bus.o_anode  <= '1;
            bus.o_frame  <= 1'b0;
        end else begin
            // Load is independent of the scan position; a load landing on a
            // rollover shows up together with the new digit next cycle.
            if (bus.i_load)
                shadow <= bus.i_data;

            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            bus.o_nibble <= shadow[4*idx +: 4];
            bus.o_anode  <= anode_nxt;
            bus.o_frame  <= slot_end && (idx == IDX_LAST);
        end
    end
endmodule
